// File: rtl/dmem_multicycle_responder_pkg.sv
// Shared constants for the MEM-stage data-memory responder: FSM state
// encodings, counter width and the default access latency.
package dmem_multicycle_responder_pkg;

  // Responder FSM states (2-bit encoding shared with the pipeline control).
  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_BUSY = 2'd1,
    DM_DONE = 2'd2
  } dm_state_e;

  // Default cycles from acceptance to completion; legal range 1..15.
  localparam int DM_DEFAULT_LATENCY = 3;

  // Wide enough to hold LATENCY-1 for the largest legal latency.
  localparam int DM_COUNT_W = 4;

endpackage : dmem_multicycle_responder_pkg

// File: rtl/dmem_multicycle_responder_array.sv
// Word-addressed data array: synchronous write, asynchronous read.
module dmem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Store a word on the clock edge when the write enable is set.
  // NOTE: the storage array has no reset; it maps onto RAM and its contents
  // are undefined until written.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : dmem_array

// File: rtl/dmem_multicycle_responder.sv
// MEM-stage data-memory responder. Accepts one load/store at a time, holds
// the pipeline with mem_stall for LATENCY cycles, commits the access on the
// edge entering DONE and pulses rdata_valid for one cycle on completed reads.
module dmem_multicycle_responder
  import dmem_multicycle_responder_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = DM_DEFAULT_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              mem_stall
);

  localparam logic [DM_COUNT_W-1:0] COUNT_INIT = DM_COUNT_W'(LATENCY - 1);

  dm_state_e               state_q, state_d;
  logic [DM_COUNT_W-1:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    is_write_q, is_write_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    rdata_valid_q, rdata_valid_d;

  logic                    req;
  logic                    accept;
  logic                    commit;
  logic                    commit_is_write;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [DEPTH_LOG2-1:0]   commit_idx;
  logic [DATA_W-1:0]       commit_wdata;
  logic                    arr_we;
  logic [DATA_W-1:0]       arr_rdata;

  // Byte-lane and upper address bits are deliberately ignored (aliasing).
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  assign req     = mem_read | mem_write;
  assign req_idx = addr[DEPTH_LOG2+1:2];
  assign accept  = (state_q == DM_IDLE) && req;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> BUSY/DONE on a request, BUSY counts down, DONE
  // lasts one cycle.
  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DM_IDLE: begin
        if (req) begin
          state_d = (LATENCY == 1) ? DM_DONE : DM_BUSY;
        end
      end
      DM_BUSY: begin
        if (count_q == DM_COUNT_W'(1)) begin
          state_d = DM_DONE;
        end
      end
      DM_DONE: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  // FSM outputs: pipeline stall and array commit controls. With LATENCY=1
  // the commit edge is also the accept edge, so the live request is used.
  always_comb begin
    mem_stall       = ~reset & (accept | (state_q == DM_BUSY));
    commit          = ~reset & (state_d == DM_DONE);
    commit_idx      = idx_q;
    commit_wdata    = wdata_q;
    commit_is_write = is_write_q;
    if (state_q == DM_IDLE) begin
      commit_idx      = req_idx;
      commit_wdata    = wdata;
      commit_is_write = mem_write;
    end
    arr_we = commit & commit_is_write;
  end

  // Datapath next values: latency counter, request latches, read data.
  always_comb begin
    count_d       = count_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    is_write_d    = is_write_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    if (accept) begin
      count_d    = COUNT_INIT;
      idx_d      = req_idx;
      wdata_d    = wdata;
      is_write_d = mem_write;
    end else if (state_q == DM_BUSY) begin
      count_d = count_q - DM_COUNT_W'(1);
    end
    if (commit && !commit_is_write) begin
      rdata_d       = arr_rdata;
      rdata_valid_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      is_write_q    <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      is_write_q    <= is_write_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  dmem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clock(clock),
    .we   (arr_we),
    .waddr(commit_idx),
    .wdata(commit_wdata),
    .raddr(commit_idx),
    .rdata(arr_rdata)
  );

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule : dmem_multicycle_responder

// File: doc/dmem_multicycle_responder.md
Name: dmem_multicycle_responder

Overview:
- Data-memory responder for the MEM pipe stage.
- Consumes the MemRead/MemWrite requests driven by main control through EX/MEM, and performs each access with a fixed multi-cycle latency.
- Returns a mem_stall signal that freezes PC, IF/ID, ID/EX and EX/MEM while an access is in flight.
- Returns read data plus a one-cycle valid pulse for MEM/WB capture.

Parameters:
- DATA_W, 32, data word width
- DEPTH_LOG2, 10, log2 of the number of words in the array
- LATENCY, 3, cycles from request acceptance to completion; legal range 1..15

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mem_read  input  1  EX/MEM MemRead; held stable by the pipeline while mem_stall=1
- mem_write  input  1  EX/MEM MemWrite; held stable while mem_stall=1
- addr  input  32  byte address (ALU result)
- wdata  input  DATA_W  store data (rt value)
- rdata  output  DATA_W  registered read data
- rdata_valid  output  1  one-cycle pulse: rdata updated by a completed read
- mem_stall  output  1  pipeline freeze request

Behaviour:
- Clock and reset: one clock (clock). Asynchronous active-high reset (reset).
- Reset values: state=IDLE, count=0, rdata=0, rdata_valid=0, latched request cleared, mem_stall=0.
- Memory array contents are not reset.
- Word index is addr[DEPTH_LOG2+1:2]. addr[1:0] and the upper bits are ignored, so out-of-range addresses alias (wrap).
- FSM states:
  - IDLE: if mem_read|mem_write, accept the request and latch addr, wdata, and is_write=mem_write.
    - Go to BUSY with count=LATENCY-1 when LATENCY>1.
    - Go straight to DONE when LATENCY=1.
  - BUSY: decrement count each cycle; go to DONE on the edge where count==1.
  - DONE: lasts exactly one cycle, then go to IDLE unconditionally.
- Commit timing: on the edge entering DONE:
  - a write stores the latched wdata at the latched index;
  - a read loads rdata from the latched index.
  - rdata_valid=1 during DONE only for reads; rdata holds its value until the next completed read.
- mem_stall is combinational: (state==IDLE && (mem_read|mem_write)) || state==BUSY.
- mem_stall is 0 in DONE, so the pipeline advances at the end of DONE.
- Latency: a request first seen at cycle t stalls cycles t..t+LATENCY-1. DONE and valid data occur at cycle t+LATENCY.
- Back-to-back accesses: a request present in the cycle after DONE is a new access and stalls again. There is no request pipelining.
- mem_read and mem_write both high: treat as a write; rdata_valid stays 0.
- Inputs changing during BUSY (flush, or a protocol violation) are ignored. The access completes using the latched values.
- Reset mid-access:
  - return to IDLE immediately;
  - no write commits;
  - rdata_valid does not pulse;
  - mem_stall drops asynchronously with reset.
- Read-after-write to the same word in consecutive accesses returns the new data, because the write has committed before the read is accepted.

Decomposition:
- Shared constants header (alongside the existing opcode constants): FSM state encodings DM_IDLE, DM_BUSY, DM_DONE (2 bits), and the default LATENCY.
- Sub-module dmem_array: synchronous-write, asynchronous-read word array. Parameters DATA_W and DEPTH_LOG2; ports clock, we, waddr, wdata, raddr, rdata.
- The responder holds the FSM, counter, latches and rdata register.

Test Plan:
1. LATENCY=3, write 0xDEADBEEF to 0x10 at cycle t -> mem_stall=1 at t, t+1, t+2 and 0 at t+3. Then read 0x10 -> rdata=0xDEADBEEF and rdata_valid=1 exactly at accept+3.
2. Read 0x10 immediately followed by read 0x14 (preloaded 0x12345678) -> two separate 3-cycle stalls with one non-stall DONE cycle between. rdata_valid pulses twice with correct data.
3. Preload 0x20=0x11111111. Write 0x22222222 to 0x20, assert reset at accept+1 -> mem_stall=0 at once, state IDLE, no valid pulse. A later read of 0x20 returns 0x11111111.
4. mem_read=mem_write=1, addr=0x30, wdata=0xA5A5A5A5 -> stall 3 cycles, rdata_valid stays 0, rdata unchanged. A later read of 0x30 returns 0xA5A5A5A5.
5. DEPTH_LOG2=10: write 0xCAFEF00D to 0x1000, then read 0x0 -> 0xCAFEF00D (alias). Read 0x3 -> same word.
6. LATENCY=1 instance: any request -> mem_stall high exactly one cycle, completion in the next cycle. Change addr during the stall cycle -> latched address is used.
